// File: rtl/truth_table_checker.sv
// Exhaustive response checker for a 4-input, 1-output combinational unit.
// Walks vectors 0..15 on vec_out. Each vector is held for SETTLE cycles, then
// dut_out is sampled and compared against the EXPECTED truth table. The block
// reports the error count and the first failing vector.
module truth_table_checker #(
  parameter logic [15:0] EXPECTED = 16'hFF80,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned ERR_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic [3:0]       vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [3:0]       first_err_vec
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // The settle counter needs at least one bit, even when SETTLE == 1.
  localparam int unsigned   CntW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleMax = CntW'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ErrMax   = '1;

  logic [1:0]       state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [3:0]       fvec_q, fvec_d;

  // Next-state logic: start or restart the run, and handle settle and sample edges.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          vec_d   = 4'd0;
          cnt_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fvec_d  = 4'd0;
        end
      end
      StDrive: begin
        if (cnt_q != SettleMax) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          if (dut_out != EXPECTED[vec_q]) begin
            if (err_q != ErrMax) begin
              err_d = err_q + 1'b1;
            end
            // Record only the first mismatch; saturation of the count does not affect it.
            if (!fev_q) begin
              fev_d  = 1'b1;
              fvec_d = vec_q;
            end
          end
          if (vec_q == 4'd15) begin
            state_d = StDone;
          end else begin
            vec_d = vec_q + 4'd1;
            cnt_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; an asynchronous reset discards any partial results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= 4'd0;
      cnt_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fvec_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
    end
  end

  // Status outputs are decoded from state, so reset clears them immediately.
  always_comb begin
    busy            = (state_q == StDrive);
    done            = (state_q == StDone);
    pass            = (state_q == StDone) && (err_q == '0);
    vec_out         = vec_q;
    err_count       = err_q;
    first_err_valid = fev_q;
    first_err_vec   = fvec_q;
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker. Three instances are used:
// dut_a has the default parameters, dut_b has ERR_W=3 and dut_c has SETTLE=1.
// Each instance's dut_out comes from a behavioural unit model that is
// correct, or is wrong on selected vectors.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst;
  logic start_ab, start_c;
  int   mode;

  logic [3:0] vec_a, vec_b, vec_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [4:0] err_a, err_c;
  logic [2:0] err_b;
  logic       fev_a, fev_b, fev_c;
  logic [3:0] fvec_a, fvec_b, fvec_c;
  logic       out_a, out_b, out_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Unit model: b = r | (c & g & p), optionally corrupted on selected vectors.
  function automatic logic model_b(input logic [3:0] v, input int m);
    logic good;
    good = v[3] | (v[2] & v[1] & v[0]);
    case (m)
      1:       return good ^ ((v == 4'd5) || (v == 4'd9));
      2:       return ~good;
      3:       return good ^ (v == 4'd15);
      default: return good;
    endcase
  endfunction

  assign out_a = model_b(vec_a, mode);
  assign out_b = model_b(vec_b, mode);
  assign out_c = model_b(vec_c, mode);

  truth_table_checker dut_a (
    .clk(clk), .rst(rst), .start(start_ab), .dut_out(out_a), .vec_out(vec_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_valid(fev_a), .first_err_vec(fvec_a)
  );

  truth_table_checker #(.ERR_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_ab), .dut_out(out_b), .vec_out(vec_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_valid(fev_b), .first_err_vec(fvec_b)
  );

  truth_table_checker #(.SETTLE(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .dut_out(out_c), .vec_out(vec_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_err_valid(fev_c), .first_err_vec(fvec_c)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int mode;
    int exp_pass;
    int exp_err_a;
    int exp_err_b;
    int exp_fev;
    int exp_fvec;
    int exp_err_pre;  // dut_a count before the final sample edge
  } vec_t;

  vec_t tbl[4];

  // Runs dut_a and dut_b together with SETTLE=2 and checks the vector walk and run length.
  task automatic run_ab(output int cycles, output int pre_last);
    int bad_walk;
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    cycles   = 0;
    bad_walk = 0;
    pre_last = -1;
    while (busy_a && cycles < 100) begin
      if (int'(vec_a) != cycles / 2) bad_walk++;
      pre_last = int'(err_a);
      cycles++;
      tick();
    end
    chk("vec_walk_mismatches", bad_walk, 0);
  endtask

  initial begin
    int cyc, pre, n;
    tbl[0] = '{0, 1, 0,  0, 0, 0,  0};
    tbl[1] = '{1, 0, 2,  2, 1, 5,  2};
    tbl[2] = '{2, 0, 16, 7, 1, 0,  15};
    tbl[3] = '{3, 0, 1,  1, 1, 15, 0};

    rst = 1'b1; start_ab = 1'b0; start_c = 1'b0; mode = 0;
    #3;
    chk("rst_vec", int'(vec_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_fev", int'(fev_a), 0);
    chk("rst_fvec", int'(fvec_a), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(busy_a), 0);

    // Table-driven full runs.
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run_ab(cyc, pre);
      chk($sformatf("t%0d_busy_cycles", i), cyc, 32);
      chk($sformatf("t%0d_err_before_last", i), pre, tbl[i].exp_err_pre);
      chk($sformatf("t%0d_done", i), int'(done_a), 1);
      chk($sformatf("t%0d_pass", i), int'(pass_a), tbl[i].exp_pass);
      chk($sformatf("t%0d_err_a", i), int'(err_a), tbl[i].exp_err_a);
      chk($sformatf("t%0d_fev", i), int'(fev_a), tbl[i].exp_fev);
      chk($sformatf("t%0d_fvec", i), int'(fvec_a), tbl[i].exp_fvec);
      chk($sformatf("t%0d_vec_hold", i), int'(vec_a), 15);
      chk($sformatf("t%0d_done_b", i), int'(done_b), 1);
      chk($sformatf("t%0d_err_b", i), int'(err_b), tbl[i].exp_err_b);
      chk($sformatf("t%0d_fvec_b", i), int'(fvec_b), tbl[i].exp_fvec);
      tick();
      chk($sformatf("t%0d_done_holds", i), int'(done_a), 1);
    end

    // Reset mid-run at vec 7 with one error already captured (at vec 5).
    mode = 1;
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    n = 0;
    while (vec_a != 4'd7 && n < 100) begin
      n++;
      tick();
    end
    chk("mid_reached_vec7", int'(vec_a), 7);
    chk("mid_err_before_rst", int'(err_a), 1);
    chk("mid_fev_before_rst", int'(fev_a), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_vec", int'(vec_a), 0);
    chk("async_rst_err", int'(err_a), 0);
    chk("async_rst_fev", int'(fev_a), 0);
    chk("async_rst_fvec", int'(fvec_a), 0);
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_done", int'(done_a), 0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", int'(busy_a), 0);
    mode = 0;
    run_ab(cyc, pre);
    chk("post_rst_cycles", cyc, 32);
    chk("post_rst_pass", int'(pass_a), 1);
    chk("post_rst_err", int'(err_a), 0);

    // SETTLE=1 with start held high: no restart mid-run, then a restart from DONE.
    mode = 1;
    start_c = 1'b1;
    tick();
    n = 0;
    cyc = 0;
    while (busy_c && cyc < 100) begin
      if (int'(vec_c) != cyc) n++;
      cyc++;
      tick();
    end
    chk("s1_busy_cycles", cyc, 16);
    chk("s1_walk_mismatches", n, 0);
    chk("s1_done", int'(done_c), 1);
    chk("s1_err", int'(err_c), 2);
    chk("s1_fvec", int'(fvec_c), 5);
    chk("s1_pass", int'(pass_c), 0);
    tick();
    mode = 0;
    chk("s1_restart_busy", int'(busy_c), 1);
    chk("s1_restart_vec", int'(vec_c), 0);
    chk("s1_restart_err", int'(err_c), 0);
    chk("s1_restart_fev", int'(fev_c), 0);
    chk("s1_restart_fvec", int'(fvec_c), 0);
    chk("s1_restart_pass", int'(pass_c), 0);
    start_c = 1'b0;
    n = 0;
    while (!done_c && n < 100) begin
      n++;
      tick();
    end
    chk("s1_second_done", int'(done_c), 1);
    chk("s1_second_pass", int'(pass_c), 1);
    chk("s1_second_err", int'(err_c), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
